// File: rtl/flit_sender.sv
// Flit sender: pops flits from an upstream buffer into a single registered link
// stage and tracks packet framing (header, size, payload) to flag the last flit.
`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif
`ifndef TAM_BUFFER
`define TAM_BUFFER 16
`endif

module flit_sender #(
   parameter int WIDTH = `TAM_FLIT,
   parameter int DEPTH = `TAM_BUFFER
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         head,
   input  logic [$clog2(DEPTH):0]   counter,
   output logic                     pull,
   output logic                     tx,
   output logic [WIDTH-1:0]         data_out,
   input  logic                     credit_i,
   output logic                     busy,
   output logic                     pkt_done
);

   typedef enum logic [1:0] {
      S_HEADER,
      S_SIZE,
      S_PAYLOAD
   } state_t;

   state_t             r_state;
   state_t             w_stateNext;
   logic [WIDTH-1:0]   r_remaining;
   logic [WIDTH-1:0]   w_remainingNext;
   logic [WIDTH-1:0]   r_data;
   logic               r_tx;
   logic               r_last;
   logic               w_lastNext;
   logic               r_pktDone;
   logic               r_armed;
   logic               w_accept;
   logic               w_free;
   logic               w_pull;

   assign w_accept = r_tx & credit_i;
   assign w_free   = ~r_tx | w_accept;
   // r_armed keeps the edge that coincides with reset release from pulling
   assign w_pull   = r_armed & (counter != '0) & w_free;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_HEADER;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      if (w_pull) begin
         case (r_state)
            S_HEADER:  w_stateNext = S_SIZE;
            S_SIZE:    w_stateNext = (head == '0) ? S_HEADER : S_PAYLOAD;
            S_PAYLOAD: w_stateNext = (r_remaining <= WIDTH'(1)) ? S_HEADER : S_PAYLOAD;
            default:   w_stateNext = S_HEADER;
         endcase
      end
   end

   always_comb begin
      w_lastNext      = 1'b0;
      w_remainingNext = r_remaining;
      if (w_pull) begin
         case (r_state)
            S_SIZE: begin
               w_remainingNext = head;
               w_lastNext      = (head == '0);
            end
            S_PAYLOAD: begin
               if (r_remaining != '0) begin
                  w_remainingNext = r_remaining - WIDTH'(1);
               end
               w_lastNext = (r_remaining <= WIDTH'(1));
            end
            default: begin
               w_lastNext      = 1'b0;
               w_remainingNext = r_remaining;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_armed     <= 1'b0;
         r_data      <= '0;
         r_tx        <= 1'b0;
         r_last      <= 1'b0;
         r_remaining <= '0;
         r_pktDone   <= 1'b0;
      end else begin
         r_armed     <= 1'b1;
         r_remaining <= w_remainingNext;
         r_pktDone   <= w_accept & r_last;
         if (w_pull) begin
            r_data <= head;
            r_tx   <= 1'b1;
            r_last <= w_lastNext;
         end else if (w_accept) begin
            r_tx <= 1'b0;
         end
      end
   end

   assign pull     = w_pull;
   assign tx       = r_tx;
   assign data_out = r_data;
   assign pkt_done = r_pktDone;
   assign busy     = (r_state != S_HEADER) | r_tx;

endmodule

// File: tb/tb_flit_sender.sv
// Randomized self-checking bench for flit_sender against a packet-level model
// of the upstream buffer and the single-entry link register.
module tb_flit_sender;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clock;
   logic             reset;
   logic [WIDTH-1:0] head;
   logic [CW-1:0]    counter;
   logic             pull;
   logic             tx;
   logic [WIDTH-1:0] data_out;
   logic             credit_i;
   logic             busy;
   logic             pkt_done;

   flit_sender #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .head     (head),
      .counter  (counter),
      .pull     (pull),
      .tx       (tx),
      .data_out (data_out),
      .credit_i (credit_i),
      .busy     (busy),
      .pkt_done (pkt_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [WIDTH-1:0] data;
      bit               isLast;
      int               pid;
   } flit_t;

   flit_t q[$];
   int    nextPid = 0;

   int nCompared   = 0;
   int nMismatched = 0;

   // Model of the link register and packet progress, kept at flit/packet level
   bit               mTx;
   logic [WIDTH-1:0] mData;
   bit               mLast;
   bit               mDone;
   bit               mArmed;
   bit               midPacket;
   int               curPid;
   bit               didReset;
   int               nAccepts;
   int               nDones;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic genPacket();
      int n;
      flit_t f;
      if ($urandom_range(0, 7) == 0) n = 16;
      else if ($urandom_range(0, 3) == 0) n = 0;
      else n = $urandom_range(1, 5);
      f.pid = nextPid;
      f.data = WIDTH'($urandom);
      f.isLast = 1'b0;
      q.push_back(f);
      f.data = WIDTH'(n);
      f.isLast = (n == 0);
      q.push_back(f);
      for (int i = 0; i < n; i++) begin
         f.data = WIDTH'($urandom);
         f.isLast = (i == n - 1);
         q.push_back(f);
      end
      nextPid++;
   endtask

   function automatic int pidLeft(input int pid);
      int c = 0;
      foreach (q[i]) if (q[i].pid == pid) c++;
      return c;
   endfunction

   task automatic checkAll(input bit expPull);
      checkOutput("pull", {31'd0, pull}, {31'd0, expPull});
      checkOutput("tx", {31'd0, tx}, {31'd0, mTx});
      checkOutput("data_out", {16'd0, data_out}, {16'd0, mData});
      checkOutput("busy", {31'd0, busy}, {31'd0, (midPacket | mTx)});
      checkOutput("pkt_done", {31'd0, pkt_done}, {31'd0, mDone});
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge
   task automatic applyStimulus(input bit allowStall, input bit randomCredit);
      int  avail;
      bit  expPull;
      bit  accept;
      flit_t f;
      while (q.size() < 24) genPacket();
      credit_i = randomCredit ? ($urandom_range(0, 3) != 0) : 1'b1;
      avail = (q.size() > DEPTH) ? DEPTH : q.size();
      if (allowStall && $urandom_range(0, 5) == 0) avail = 0;
      counter = CW'(avail);
      head = (avail != 0) ? q[0].data : WIDTH'($urandom);
      #1;
      expPull = mArmed && (avail != 0) && (!mTx || credit_i);
      checkAll(expPull);
      @(posedge clock);
      accept = mTx && credit_i;
      mDone = accept && mLast;
      if (accept) nAccepts++;
      if (mDone) nDones++;
      if (expPull) begin
         f = q.pop_front();
         mData = f.data;
         mTx = 1'b1;
         mLast = f.isLast;
         midPacket = !f.isLast;
         curPid = f.pid;
      end else if (accept) begin
         mTx = 1'b0;
      end
      mArmed = 1'b1;
      @(negedge clock);
   endtask

   task automatic doReset();
      reset = 1'b0;
      #1;
      mTx = 1'b0;
      mData = '0;
      mLast = 1'b0;
      mDone = 1'b0;
      mArmed = 1'b0;
      if (midPacket) begin
         while (q.size() > 0 && q[0].pid == curPid) void'(q.pop_front());
      end
      midPacket = 1'b0;
      checkAll(1'b0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      didReset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      credit_i = 1'b1;
      counter = CW'(5);
      head = 16'hBEEF;
      mTx = 1'b0;
      mData = '0;
      mLast = 1'b0;
      mDone = 1'b0;
      mArmed = 1'b0;
      midPacket = 1'b0;
      curPid = -1;
      didReset = 1'b0;
      nAccepts = 0;
      nDones = 0;
      repeat (3) @(negedge clock);
      #1;
      checkAll(1'b0);
      @(negedge clock);
      reset = 1'b1;

      for (int c = 0; c < 120; c++) applyStimulus(1'b0, 1'b0);
      for (int c = 0; c < 300; c++) begin
         applyStimulus(1'b1, 1'b1);
         if (!didReset && c > 50 && midPacket && pidLeft(curPid) == 3) doReset();
      end
      if (!didReset) doReset();
      for (int c = 0; c < 300; c++) applyStimulus(1'b1, 1'b1);
      for (int c = 0; c < 80; c++) applyStimulus(1'b0, 1'b0);

      $display("[TB] accepts=%0d packets=%0d", nAccepts, nDones);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/flit_sender.md
FLIT_SENDER -- requirements
Module: flit_sender

Interface
REQ-001 SHALL have parameter WIDTH, default `TAM_FLIT (16), flit width in bits.
REQ-002 SHALL have parameter DEPTH, default `TAM_BUFFER (16), depth of the upstream buffer whose occupancy is read.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port head  input  WIDTH  flit currently at the upstream buffer head.
REQ-006 SHALL have port counter  input  $clog2(DEPTH)+1  upstream buffer occupancy in flits.
REQ-007 SHALL have port pull  output  1  pops the upstream head at this rising edge.
REQ-008 SHALL have port tx  output  1  flit on data_out is valid on the link.
REQ-009 SHALL have port data_out  output  WIDTH  registered link flit.
REQ-010 SHALL have port credit_i  input  1  downstream can accept a flit this cycle.
REQ-011 SHALL have port busy  output  1  a packet is partially sent (mid-packet or output register occupied).
REQ-012 SHALL have port pkt_done  output  1  one-cycle pulse when the last flit of a packet is accepted downstream.

Function
REQ-013 SHALL treat a packet as header flit, size flit (value N = payload count, 0..2^WIDTH-1), then N payload flits.
REQ-014 SHALL define accept = tx & credit_i; a flit is transferred to the link only on accept.
REQ-015 SHALL hold one output register (data_out, tx, last flag); register is free when tx=0 or accept=1.
REQ-016 SHALL assert pull combinationally iff counter != 0 and the output register is free; pull is never 1 when counter == 0.
REQ-017 SHALL, on a pull edge, load head into data_out and set tx=1 next cycle; otherwise, if accept, clear tx; otherwise hold data_out and tx.
REQ-018 SHALL provide 1-cycle latency from pull to tx and sustain 1 flit/cycle when counter != 0 and credit_i stays 1.
REQ-019 SHALL keep data_out and tx stable while tx=1 and credit_i=0.
REQ-020 SHALL track the loaded flit with FSM states S_HEADER, S_SIZE, S_PAYLOAD; transitions occur only on pull.
REQ-021 SHALL transition S_HEADER -> S_SIZE on pull (flit marked header, last=0).
REQ-022 SHALL, in S_SIZE on pull, latch remaining = head (WIDTH bits); if head == 0, mark the flit last and go to S_HEADER, else go to S_PAYLOAD.
REQ-023 SHALL, in S_PAYLOAD on pull, decrement remaining; when remaining == 1 before the decrement, mark the flit last and go to S_HEADER.
REQ-024 SHALL pulse pkt_done for exactly the cycle following an accept of a flit marked last.
REQ-025 SHALL drive busy = (state != S_HEADER) | tx.
REQ-026 SHALL handle remaining in full WIDTH unsigned arithmetic, with no wrap below 0 (decrement only when remaining >= 1).
REQ-027 SHALL start the next packet's header on the pull immediately after the last flit is loaded (no idle gap).

Reset
REQ-028 SHALL, while reset=0, asynchronously force tx=0, data_out=0, pkt_done=0, state=S_HEADER, remaining=0, last=0; busy=0 and pull=0 follow.
REQ-029 SHALL, on reset asserted mid-packet, discard the partial packet; the first pull after release is treated as a header.
REQ-030 SHALL sample no inputs and issue no pull on the first rising edge coincident with reset release.

Verification
REQ-031 SHALL verify back-to-back: counter=5, credit_i=1, flits H,2,P0,P1 -> pull 4 consecutive cycles, tx 1 cycle later, pkt_done pulse 1 cycle after P1 accepted, busy=0 afterward.
REQ-032 SHALL verify backpressure: credit_i=0 for 3 cycles while tx=1 with data_out=0xA5A5 -> data_out held at 0xA5A5, pull=0, no pkt_done.
REQ-033 SHALL verify zero-size packet: flits H,0 -> last on size flit, pkt_done after its accept, next flit treated as header.
REQ-034 SHALL verify empty buffer: counter=0 mid-packet -> pull=0, tx drops after accept, state retained; resumes when counter=1.
REQ-035 SHALL verify reset mid-payload (remaining=3) -> tx=0, busy=0 immediately; after release, next flit loaded as header.
REQ-036 SHALL verify simultaneous accept and pull every cycle for a 16-payload packet -> 18 accepts in 18 cycles, one pkt_done.
